// File: rtl/mul_seq_unit.sv
// Iterative radix-2 shift-add multiplier for the EX stage.
// Operands are converted to magnitudes at start, multiplied unsigned over
// WIDTH cycles, and the sign is re-applied on the final iteration so the
// registered result is valid in the single DONE cycle.
//
// Handshake: start_i is a request that is accepted only when the unit is not
// running (IDLE or DONE) and flush_i is low; there is no ready signal, the
// requester watches busy_o. done_o is a one-cycle valid pulse for result_o,
// which holds until the next completed operation.
module mul_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic [1:0]         state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               last_iter;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               sign_q;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] result_next;

  assign state_o   = state_q;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the correct
  // unsigned magnitude.
  assign mag1 = (signed_i && src1_i[WIDTH-1]) ? -src1_i : src1_i;
  assign mag2 = (signed_i && src2_i[WIDTH-1]) ? -src2_i : src2_i;

  // One shift-add step: conditional add into the upper half with carry, then
  // shift {carry, product} right by one.
  always_comb begin
    addend      = mplier_q[0] ? mcand_q : '0;
    sum         = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_step   = {sum, prod_q[WIDTH-1:1]};
    result_next = sign_q ? -prod_step : prod_step;
  end

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything, including a start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          accept  = 1'b1;
        end
      end
      S_RUN: begin
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        if (start_i) begin
          state_d = S_RUN;
          accept  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      accept  = 1'b0;
    end
  end

  // Registered status outputs follow the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (state_d == S_RUN);
      done_o <= (state_d == S_DONE);
    end
  end

  // Datapath: latch on accept, iterate while running, publish on last step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      result_o <= '0;
    end else if (accept) begin
      mcand_q  <= mag1;
      mplier_q <= mag2;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
    end else if (state_q == S_RUN && !flush_i) begin
      prod_q   <= prod_step;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last_iter) result_o <= result_next;
    end
  end

endmodule

// File: doc/mul_seq_unit.md
# mul_seq_unit

Iterative radix-2 shift-add multiplier in the EX stage, beside the single-cycle ALU. It takes the same two 32-bit register operands the ALU receives. It produces a 64-bit product after a fixed 32-cycle run, and the result is muxed into the EX/MEM pipeline register in place of the ALU result. While it runs, `busy_o` stalls IF/ID/EX; `flush_i` from branch/exception logic aborts it.

## Interface
- `WIDTH`, 32: operand width; product is 2*WIDTH; iteration count equals WIDTH.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  request a multiply; sampled only in IDLE or DONE.
- `signed_i`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start_i`.
- `src1_i`  in  WIDTH  multiplicand; sampled with `start_i`.
- `src2_i`  in  WIDTH  multiplier; sampled with `start_i`.
- `flush_i`  in  1  abort any operation in progress; return to IDLE.
- `busy_o`  out  1  high while in RUN; drives pipeline stall.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid and new.
- `result_o`  out  2*WIDTH  product; holds its value until the next completed operation.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- **Reset (async):** state=IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, internal counter and accumulators=0.
- **IDLE**
  - `start_i`=1 and `flush_i`=0 → latch operands and `signed_i` → RUN.
  - Latched operands are magnitudes: if `signed_i` and operand[WIDTH-1] is set, latch its negation; otherwise latch the operand.
  - Record result sign = `signed_i` & (src1[MSB] ^ src2[MSB]).
  - Clear the product accumulator and counter.
- **RUN**, each cycle:
  - If multiplier[0], add the multiplicand to the product upper half, WIDTH+1 bits with carry.
  - Shift {carry, product} right by 1, shifting multiplier bits out.
  - Counter increments.
  - After WIDTH iterations → DONE.
- **DONE**
  - `result_o` = sign ? −product : product (2*WIDTH-bit two's complement).
  - `done_o`=1 for exactly this cycle.
  - `start_i`=1 here is accepted (back-to-back) → RUN; otherwise → IDLE.
- **Width rules:** the magnitude of −2^(WIDTH-1) is 2^(WIDTH-1) and fits unsigned WIDTH. No overflow is possible; the full 2*WIDTH product is always exact.
- **Start gating:** `start_i` during RUN is ignored. No queuing; operands are not re-sampled.
- **Flush:**
  - `flush_i`=1 in any state → IDLE next edge, `done_o`=0, `result_o` unchanged.
  - `flush_i` and `start_i` together: flush wins, start discarded.

## Timing
- `start_i` sampled at edge E0.
- `busy_o` is high from after E0 through edge E0+WIDTH (WIDTH cycles).
- State is DONE after edge E0+WIDTH. `done_o` and the new `result_o` are visible in that cycle and sampled by EX/MEM at edge E0+WIDTH+1.
- Latency start→done: WIDTH+1 edges (33 for WIDTH=32).
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- `busy_o` is low in the DONE cycle, so the stall releases in the same cycle the result is consumed.
- Reset asserted mid-RUN: immediate return to the reset values above, no done pulse. After deassertion the block accepts `start_i` on the first edge.
- Operands may change after E0 without effect.

## Test plan
- **Unsigned:** src1=0x0000_0007, src2=0x0000_0006, signed=0.
  - `done_o` exactly 33 edges after start; `result_o`=0x0000_0000_0000_002A.
  - `busy_o` high for 32 cycles.
- **Signed mixed and extremes:**
  - (−3)×5 signed → 0xFFFF_FFFF_FFFF_FFF1.
  - 0x8000_0000×0x8000_0000 signed → 0x4000_0000_0000_0000.
  - 0x8000_0000×0x8000_0000 unsigned → 0x4000_0000_0000_0000.
  - 0xFFFF_FFFF×0xFFFF_FFFF unsigned → 0xFFFF_FFFE_0000_0001.
- **Start ignored during RUN:** start 2×3, reassert start with 9×9 at cycle 10.
  - Single `done_o` at cycle 33; result=6; no second run.
- **Back-to-back:** start asserted in the DONE cycle with 4×4 after 2×3.
  - done at 33 (result 6), next done at 66 (result 16).
  - `busy_o` low only in DONE cycles.
- **Flush:** complete 2×3 (result 6), then start 7×7 and assert `flush_i` at cycle 15.
  - IDLE next edge, no `done_o`, `result_o` stays 6.
  - Flush+start in the same cycle → no run.
- **Async reset mid-RUN:** pulse `rst_i` between edges at cycle 20.
  - All outputs 0 immediately.
  - A subsequent 5×5 completes in 33 edges with result 25.
